// File: rtl/clk_based_dtc.sv
// clk_based_dtc: digital-to-time converter.
// Plays a queue of (level, width) symbols onto a single logic line. Each
// symbol holds its level for exactly max(width,1) clock cycles. Consecutive
// symbols follow each other with no gap cycles. When no symbol is active the
// line rests at IDLE_LEVEL.
module clk_based_dtc #(
    parameter int   WIDTH      = 21,
    parameter int   DEPTH      = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_level,
    input  logic [WIDTH-1:0]         in_width,
    output logic                     CAN_out,
    output logic                     busy,
    output logic                     sym_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    // Pointer and occupancy widths. DEPTH is a power of two, so pointers
    // wrap naturally when they overflow.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Symbol FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [WIDTH:0]   fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // ------------------------------------------------------------------
    // Symbol player state
    // ------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [WIDTH-1:0] counter_q,  counter_d;
    logic             can_out_q,  can_out_d;
    logic             busy_q,     busy_d;
    logic             sym_done_q, sym_done_d;

    // ------------------------------------------------------------------
    // Handshake and control decodes
    // ------------------------------------------------------------------
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             sym_last;
    logic [WIDTH:0]   head_entry;
    logic             head_level;
    logic [WIDTH-1:0] head_width;
    logic [WIDTH-1:0] load_value;

    // Occupancy flags come purely from the registered count, so in_ready has
    // no combinational dependence on the pop happening in the same cycle.
    always_comb begin
        fifo_full  = (count_q == CW'(DEPTH));
        fifo_empty = (count_q == '0);
    end

    // Head-of-queue decode and the counter reload value. A stored width of
    // zero is executed as a one-cycle symbol.
    always_comb begin
        head_entry = fifo_mem[rd_ptr_q];
        head_level = head_entry[WIDTH];
        head_width = head_entry[WIDTH-1:0];
        if (head_width == '0) begin
            load_value = '0;
        end else begin
            load_value = head_width - WIDTH'(1);
        end
    end

    // Push when the host offers and there is room. Pop either from IDLE or
    // on the final cycle of the running symbol, which gives seamless
    // back-to-back playback.
    always_comb begin
        sym_last = (state_q == S_RUN) && (counter_q == '0);
        push     = in_valid && !fifo_full;
        pop      = enable && !fifo_empty && ((state_q == S_IDLE) || sym_last);
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset because the pointers and
    // count define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_level, in_width};
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Player state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Player next-state: start on a pop from IDLE, leave RUN only when the
    // final cycle of a symbol has no successor ready to start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sym_last && !pop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Player outputs: reload the counter and line level on a pop, count down
    // while a symbol runs, and return the line to idle when playback stops.
    always_comb begin
        counter_d  = counter_q;
        can_out_d  = can_out_q;
        sym_done_d = sym_last;
        busy_d     = (state_d == S_RUN);
        if (pop) begin
            counter_d = load_value;
            can_out_d = head_level;
        end else if (sym_last) begin
            counter_d = '0;
            can_out_d = IDLE_LEVEL;
        end else if ((state_q == S_RUN) && (counter_q != '0)) begin
            counter_d = counter_q - WIDTH'(1);
        end else if (state_q == S_IDLE) begin
            can_out_d = IDLE_LEVEL;
        end
    end

    // Player output registers; reset drops the line to idle immediately,
    // even in the middle of a symbol.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            counter_q  <= '0;
            can_out_q  <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            sym_done_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            can_out_q  <= can_out_d;
            busy_q     <= busy_d;
            sym_done_q <= sym_done_d;
        end
    end

    // Output drive: everything registered except in_ready, which is a
    // decode of the registered count.
    always_comb begin
        in_ready   = !fifo_full;
        CAN_out    = can_out_q;
        busy       = busy_q;
        sym_done   = sym_done_q;
        fifo_count = count_q;
    end

endmodule

// File: tb/tb_clk_based_dtc.sv
// Bench for clk_based_dtc: a queue-based model of the symbol player is
// compared against the DUT every cycle, and directed scenarios pin the
// waveform with hand-computed run lengths.
module tb_clk_based_dtc;

    localparam int W     = 12;
    localparam int DEPTH = 4;
    localparam int MAXW  = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         enable = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_level = 1'b0;
    logic [W-1:0] in_width = '0;
    logic         in_ready;
    logic         CAN_out;
    logic         busy;
    logic         sym_done;
    logic [2:0]   fifo_count;

    clk_based_dtc #(
        .WIDTH(W),
        .DEPTH(DEPTH),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .enable(enable),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_level(in_level),
        .in_width(in_width),
        .CAN_out(CAN_out),
        .busy(busy),
        .sym_done(sym_done),
        .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic level;
        int   width;
    } sym_t;

    sym_t m_q[$];
    sym_t m_s;
    logic m_line = 1'b1;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_rem  = 0;   // cycles left in current symbol, including this one
    bit   m_accept;
    bit   m_pop;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_q.delete();
            m_line = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rem  = 0;
        end else begin
            m_accept = in_valid && (m_q.size() < DEPTH);
            m_pop    = enable && (m_q.size() > 0) && (!m_busy || m_rem == 1);
            m_done   = m_busy && (m_rem == 1);
            if (m_pop) begin
                m_s    = m_q.pop_front();
                m_line = m_s.level;
                m_rem  = (m_s.width == 0) ? 1 : m_s.width;
                m_busy = 1'b1;
            end else if (m_busy && m_rem == 1) begin
                m_busy = 1'b0;
                m_line = 1'b1;
                m_rem  = 0;
            end else if (m_busy) begin
                m_rem = m_rem - 1;
            end
            if (m_accept) begin
                m_s.level = in_level;
                m_s.width = int'(in_width);
                m_q.push_back(m_s);
            end
        end
    end

    // ---------------- checking ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   log_en   = 1'b0;
    logic log_can[$];
    logic log_done[$];
    logic log_busy[$];
    int   runs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle, then compare every output against the model.
    task automatic tick();
        @(negedge CLK);
        check("CAN_out",    32'(CAN_out),    32'(m_line));
        check("busy",       32'(busy),       32'(m_busy));
        check("sym_done",   32'(sym_done),   32'(m_done));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("in_ready",   32'(in_ready),   32'(m_q.size() < DEPTH));
        if (log_en) begin
            log_can.push_back(CAN_out);
            log_done.push_back(sym_done);
            log_busy.push_back(busy);
        end
    endtask

    task automatic clear_log();
        log_can.delete();
        log_done.delete();
        log_busy.delete();
    endtask

    task automatic push1(input logic lvl, input int wid);
        in_valid = 1'b1;
        in_level = lvl;
        in_width = W'(wid);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int count_can(input logic v);
        int n = 0;
        foreach (log_can[i]) if (log_can[i] === v) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (log_done[i]) if (log_done[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_busy();
        int n = 0;
        foreach (log_busy[i]) if (log_busy[i] === 1'b1) n++;
        return n;
    endfunction

    // Run lengths of CAN_out starting at the first low sample.
    function automatic void calc_runs();
        int   s;
        int   len;
        logic cur;
        runs.delete();
        s = -1;
        foreach (log_can[i]) if (s < 0 && log_can[i] === 1'b0) s = i;
        if (s < 0) return;
        cur = log_can[s];
        len = 0;
        for (int i = s; i < log_can.size(); i++) begin
            if (log_can[i] === cur) begin
                len++;
            end else begin
                runs.push_back(len);
                cur = log_can[i];
                len = 1;
            end
        end
        runs.push_back(len);
    endfunction

    function automatic int run_at(input int idx);
        if (idx < runs.size()) return runs[idx];
        return -1;
    endfunction

    initial begin
        int edge_idx;

        // ---- reset state ----
        repeat (3) tick();
        RST = 1'b1;
        repeat (2) tick();
        check("rst_can",   32'(CAN_out),    32'd1);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(in_ready),   32'd1);

        // ---- single symbol {0,10} ----
        clear_log();
        log_en = 1'b1;
        enable = 1'b1;
        push1(1'b0, 10);
        repeat (14) tick();
        check("single_lat_k",  32'(log_can[0]), 32'd1);
        check("single_lat_k1", 32'(log_can[1]), 32'd0);
        check("single_low",    32'(count_can(1'b0)), 32'd10);
        check("single_done",   32'(count_done()), 32'd1);
        edge_idx = -1;
        for (int i = 1; i < log_can.size(); i++)
            if (edge_idx < 0 && log_can[i-1] === 1'b0 && log_can[i] === 1'b1) edge_idx = i;
        check("single_done_align", (edge_idx > 0) ? 32'(log_done[edge_idx]) : 32'd0, 32'd1);

        // ---- back-to-back {0,3},{1,5},{0,2} ----
        clear_log();
        push1(1'b0, 3);
        push1(1'b1, 5);
        push1(1'b0, 2);
        repeat (14) tick();
        calc_runs();
        check("b2b_run0", 32'(run_at(0)), 32'd3);
        check("b2b_run1", 32'(run_at(1)), 32'd5);
        check("b2b_run2", 32'(run_at(2)), 32'd2);
        check("b2b_done", 32'(count_done()), 32'd3);

        // ---- full / backpressure ----
        enable = 1'b0;
        push1(1'b0, 2);
        push1(1'b1, 3);
        push1(1'b0, 4);
        push1(1'b1, 5);
        push1(1'b0, 6);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(in_ready),   32'd0);
        clear_log();
        enable = 1'b1;
        tick();
        check("full_ready_after_pop", 32'(in_ready),   32'd1);
        check("full_count_after_pop", 32'(fifo_count), 32'd3);
        repeat (20) tick();
        calc_runs();
        check("full_run0", 32'(run_at(0)), 32'd2);
        check("full_run1", 32'(run_at(1)), 32'd3);
        check("full_run2", 32'(run_at(2)), 32'd4);
        check("full_done", 32'(count_done()), 32'd4);

        // ---- zero width ----
        clear_log();
        push1(1'b0, 0);
        repeat (5) tick();
        check("zero_low",  32'(count_can(1'b0)), 32'd1);
        check("zero_done", 32'(count_done()), 32'd1);

        // ---- maximum width ----
        clear_log();
        push1(1'b0, MAXW);
        repeat (MAXW + 5) tick();
        check("max_low",  32'(count_can(1'b0)), 32'(MAXW));
        check("max_done", 32'(count_done()), 32'd1);

        // ---- enable drop mid-symbol ----
        enable = 1'b0;
        push1(1'b0, 8);
        push1(1'b1, 8);
        clear_log();
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        repeat (12) tick();
        check("drop_low",   32'(count_can(1'b0)), 32'd8);
        check("drop_done",  32'(count_done()), 32'd1);
        check("drop_count", 32'(fifo_count), 32'd1);
        check("drop_busy",  32'(busy), 32'd0);
        clear_log();
        enable = 1'b1;
        repeat (12) tick();
        check("reen_busy",  32'(count_busy()), 32'd8);
        check("reen_done",  32'(count_done()), 32'd1);
        check("reen_count", 32'(fifo_count), 32'd0);

        // ---- asynchronous reset mid-run ----
        enable = 1'b0;
        push1(1'b0, 20);
        push1(1'b1, 5);
        push1(1'b0, 5);
        push1(1'b1, 5);
        enable = 1'b1;
        repeat (2) tick();
        #2 RST = 1'b0;
        #1;
        check("arst_can",   32'(CAN_out),    32'd1);
        check("arst_busy",  32'(busy),       32'd0);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_ready", 32'(in_ready),   32'd1);
        check("arst_done",  32'(sym_done),   32'd0);
        repeat (2) tick();
        RST = 1'b1;
        clear_log();
        repeat (6) tick();
        check("post_rst_done", 32'(count_done()), 32'd0);
        check("post_rst_high", 32'(count_can(1'b1)), 32'd6);
        log_en = 1'b0;

        // ---- randomized traffic ----
        for (int n = 0; n < 3000; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_level = 1'($urandom_range(0, 1));
            in_width = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40))
                                                   : W'($urandom_range(0, 4));
            enable   = ($urandom_range(0, 9) != 0);
            if (!RST) RST = 1'b1;
            else if ($urandom_range(0, 399) == 0) RST = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        RST = 1'b1;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_based_dtc.md
Name: clk_based_dtc

Overview:
- Digital-to-time converter: the transmit-side counterpart of the clock-based TDC.
- Accepts a queue of (level, width) symbols and drives a CAN-style logic line. Each symbol holds its level for exactly `width` CLK cycles.
- Used to synthesise known CAN_logic waveforms on-board, so the TDC's 21-bit measurements can be checked against programmed widths.
- Sits between a host/control path (valid/ready) and the CAN_logic input of the TDC.

Parameters:
- WIDTH, 21: bit width of the symbol duration, matching the TDC out_data width.
- DEPTH, 4: symbol FIFO entries; power of two, at least 2.
- IDLE_LEVEL, 1: line level driven when no symbol is active (CAN recessive).

Ports:
- CLK  input  1  single system clock; all state on posedge.
- RST  input  1  asynchronous, active-low reset.
- enable  input  1  level; when 0, no new symbol is started.
- in_valid  input  1  symbol offered.
- in_ready  output  1  FIFO can accept; equals !full.
- in_level  input  1  line level for the offered symbol.
- in_width  input  WIDTH  duration of the offered symbol in CLK cycles.
- CAN_out  output  1  generated logic line, registered.
- busy  output  1  high while in RUN.
- sym_done  output  1  one-cycle pulse when a symbol's final cycle completes.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (RST=0, asynchronous) takes effect immediately, including mid-symbol:
  - FIFO emptied, fifo_count=0, in_ready=1.
  - State IDLE, counter=0, busy=0, sym_done=0, CAN_out=IDLE_LEVEL.
- Push: on a posedge with in_valid & in_ready, {in_level, in_width} is written.
  - The entry is visible (fifo_count updated, poppable) from the next edge.
  - in_valid while full is ignored; the entry is not stored.
- Width rule: in_width==0 is stored as-is but executed as width 1. Maximum is 2^WIDTH-1 cycles.
- State machine has two states, IDLE and RUN.
- IDLE:
  - At a posedge with enable=1 and FIFO non-empty, pop the head.
  - Same edge: CAN_out<=level, counter<=max(width,1)-1, busy<=1, go to RUN.
  - Otherwise CAN_out holds IDLE_LEVEL.
- RUN, counter>0: counter decrements each edge; CAN_out holds.
- RUN, counter==0 (final cycle of the symbol):
  - sym_done<=1 for exactly one cycle.
  - If enable=1 and FIFO non-empty: pop the next entry on this same edge. CAN_out takes the new level with zero gap cycles, and counter reloads. Stay in RUN.
  - Else: CAN_out<=IDLE_LEVEL, busy<=0, go to IDLE.
- Result: a symbol of width N drives CAN_out for exactly N consecutive cycles. Back-to-back symbols are seamless.
- Latency: a symbol accepted at edge k into an empty FIFO in IDLE is popped at edge k+1. CAN_out reflects it after edge k+1.
- enable deasserted mid-symbol: the current symbol completes at full length, then the block goes IDLE. Remaining entries are retained.
- Simultaneous push and pop:
  - Allowed when not full; fifo_count unchanged.
  - When full, in_ready=0 even if a pop occurs that edge (no combinational ready-through path).
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- No combinational path from any input to any output except in_ready, which is derived from registered count.

Test Plan:
- Reset: RST=0 mid-RUN with 3 entries queued → immediately CAN_out=1, busy=0, fifo_count=0, in_ready=1. After release, idle holds with no spurious sym_done.
- Single symbol: push {0, 10} at edge k, enable=1 → CAN_out=0 for exactly 10 cycles starting after edge k+1, then 1. One sym_done pulse, aligned with the return to 1.
- Back-to-back: push {0,3}, {1,5}, {0,2} → waveform 0×3, 1×5, 0×2, then idle 1. No gap cycles; 3 sym_done pulses.
- Full/backpressure: enable=0, push 5 entries with in_valid held high → 4 accepted, in_ready=0, fifo_count=4. Raise enable: entries play in order, and in_ready rises after the first pop.
- Zero width and maximum width: push {0,0} → CAN_out=0 for 1 cycle. Push {0, 2^21-1} → low for 2097151 cycles; the TDC-measured width matches.
- enable drop: queue {0,8}, {1,8}, drop enable at cycle 3 of the first symbol → first symbol runs the full 8 cycles, then idle with fifo_count=1. Re-enable → {1,8} plays.
